// File: rtl/host_reg_slave_if.sv
// Host register bus pins: strobes, address and data between the host CPU and the register slave.
interface host_reg_slave_if;
  logic        CSB;
  logic        WRB;
  logic [7:0]  CA;
  logic [15:0] CD_in;
  logic [15:0] CD_out;

  modport master (output CSB, output WRB, output CA, output CD_in, input CD_out);
  modport slave  (input CSB, input WRB, input CA, input CD_in, output CD_out);
endinterface

// File: rtl/host_reg_slave.sv
// Register-bus responder: one access per CSB low period into a 16-entry config bank,
// plus ID, status mirror and a saturating read-to-clear event counter.
module host_reg_slave #(
  parameter logic [15:0] ID_VALUE = 16'hE7A0
) (
  input  logic              Clk_reg,
  input  logic              Reset,
  host_reg_slave_if.slave   host,
  input  logic [15:0]       Status_in,
  input  logic              Event,
  output logic [255:0]      Cfg_out,
  output logic              Wr_pulse,
  output logic [3:0]        Wr_addr
);

  logic         csb_q, csb_qq, wrb_q;
  logic [7:0]   ca_q;
  logic [15:0]  d_q;
  logic [255:0] cfg_q, cfg_d;
  logic [15:0]  cd_q, cd_d;
  logic [15:0]  evt_cnt_q, evt_cnt_d;
  logic         wr_pulse_q, wr_pulse_d;
  logic [3:0]   wr_addr_q, wr_addr_d;

  logic         acc, rd_acc, wr_bank;
  logic [6:0]   waddr;
  logic [15:0]  rd_data;
  logic         unused_ca0;

  // Falling edge of the registered CSB marks the single access cycle.
  assign acc        = !csb_q && csb_qq;
  assign waddr      = ca_q[7:1];
  assign unused_ca0 = ca_q[0];
  assign rd_acc     = acc && wrb_q;
  assign wr_bank    = acc && !wrb_q && (waddr[6:4] == 3'b000);

  always_comb begin
    rd_data = 16'h0000;
    if (waddr[6:4] == 3'b000) begin
      rd_data = cfg_q[{waddr[3:0], 4'h0} +: 16];
    end else begin
      case (waddr)
        7'h10:   rd_data = ID_VALUE;
        7'h11:   rd_data = Status_in;
        7'h12:   rd_data = evt_cnt_q;
        default: rd_data = 16'h0000;
      endcase
    end
  end

  always_comb begin
    cfg_d = cfg_q;
    if (wr_bank) begin
      cfg_d[{waddr[3:0], 4'h0} +: 16] = d_q;
    end
    cd_d       = rd_acc ? rd_data : cd_q;
    wr_pulse_d = wr_bank;
    wr_addr_d  = wr_bank ? waddr[3:0] : wr_addr_q;
    // A clearing read keeps an event arriving in the same cycle.
    if (rd_acc && (waddr == 7'h12)) begin
      evt_cnt_d = {15'b0, Event};
    end else if (Event && (evt_cnt_q != 16'hFFFF)) begin
      evt_cnt_d = evt_cnt_q + 16'd1;
    end else begin
      evt_cnt_d = evt_cnt_q;
    end
  end

  always_ff @(posedge Clk_reg or posedge Reset) begin
    if (Reset) begin
      csb_q      <= 1'b1;
      csb_qq     <= 1'b1;
      wrb_q      <= 1'b1;
      ca_q       <= 8'h00;
      d_q        <= 16'h0000;
      cfg_q      <= '0;
      cd_q       <= 16'h0000;
      evt_cnt_q  <= 16'h0000;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 4'h0;
    end else begin
      csb_q      <= host.CSB;
      csb_qq     <= csb_q;
      wrb_q      <= host.WRB;
      ca_q       <= host.CA;
      d_q        <= host.CD_in;
      cfg_q      <= cfg_d;
      cd_q       <= cd_d;
      evt_cnt_q  <= evt_cnt_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign host.CD_out = cd_q;
  assign Cfg_out     = cfg_q;
  assign Wr_pulse    = wr_pulse_q;
  assign Wr_addr     = wr_addr_q;

endmodule

// File: tb/tb_host_reg_slave.sv
// Directed bench for host_reg_slave: bus accesses, event counter and reset behaviour.
module tb_host_reg_slave;
  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  status;
  logic         evt;
  logic [255:0] cfg;
  logic         wr_pulse;
  logic [3:0]   wr_addr;
  logic [255:0] exp_cfg;
  int           checks = 0;
  int           errors = 0;
  int           pulse_cnt = 0;
  int           p0;
  logic [3:0]   last_addr = 4'h0;

  host_reg_slave_if bus ();

  host_reg_slave dut (
    .Clk_reg   (clk),
    .Reset     (rst),
    .host      (bus),
    .Status_in (status),
    .Event     (evt),
    .Cfg_out   (cfg),
    .Wr_pulse  (wr_pulse),
    .Wr_addr   (wr_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      last_addr = wr_addr;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // rd=1 read, rd=0 write; evt_acc raises Event during the access cycle.
  task automatic access(input logic rd, input logic [7:0] ca, input logic [15:0] d,
                        input int low, input logic evt_acc);
    @(negedge clk);
    bus.CSB = 1'b0; bus.WRB = rd; bus.CA = ca; bus.CD_in = d;
    for (int i = 1; i <= low; i++) begin
      @(negedge clk);
      evt = (i == 1) ? evt_acc : 1'b0;
    end
    bus.CSB = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; bus.CSB = 1'b1; bus.WRB = 1'b1; bus.CA = 8'h00; bus.CD_in = 16'h0000;
    status = 16'h0000; evt = 1'b0; exp_cfg = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cd_out", {240'b0, bus.CD_out}, 256'h0);
    chk("reset_wr_pulse", {255'b0, wr_pulse}, 256'h0);
    chk("reset_cfg", cfg, 256'h0);

    // ID read with explicit latency check
    @(negedge clk);
    bus.CSB = 1'b0; bus.WRB = 1'b1; bus.CA = 8'h20;
    @(negedge clk);
    chk("id_before_e2", {240'b0, bus.CD_out}, 256'h0);
    @(negedge clk);
    chk("id_read", {240'b0, bus.CD_out}, {240'b0, 16'hE7A0});
    bus.CSB = 1'b1;
    repeat (2) @(negedge clk);

    // write / read-back reg 3
    p0 = pulse_cnt;
    access(1'b0, 8'h06, 16'hA5C3, 2, 1'b0);
    exp_cfg[63:48] = 16'hA5C3;
    chk("wr3_pulse_count", 256'(pulse_cnt - p0), 256'd1);
    chk("wr3_addr", {252'b0, last_addr}, {252'b0, 4'd3});
    chk("wr3_cfg", cfg, exp_cfg);
    access(1'b1, 8'h06, 16'h0000, 2, 1'b0);
    chk("rd3", {240'b0, bus.CD_out}, {240'b0, 16'hA5C3});

    // writes to read-only / reserved space
    p0 = pulse_cnt;
    access(1'b0, 8'h22, 16'h1234, 2, 1'b0);
    access(1'b0, 8'hFE, 16'h1234, 2, 1'b0);
    chk("ro_wr_no_pulse", 256'(pulse_cnt - p0), 256'd0);
    chk("ro_wr_cfg", cfg, exp_cfg);
    chk("ro_wr_cd_hold", {240'b0, bus.CD_out}, {240'b0, 16'hA5C3});
    status = 16'h0F0F;
    access(1'b1, 8'h22, 16'h0000, 2, 1'b0);
    chk("rd_status", {240'b0, bus.CD_out}, {240'b0, 16'h0F0F});
    access(1'b1, 8'hFE, 16'h0000, 2, 1'b0);
    chk("rd_reserved", {240'b0, bus.CD_out}, 256'h0);

    // event counter: 5 events, write to 0x12 must not clear
    repeat (5) begin
      @(negedge clk); evt = 1'b1;
      @(negedge clk); evt = 1'b0;
    end
    access(1'b0, 8'h24, 16'h0000, 2, 1'b0);
    access(1'b1, 8'h24, 16'h0000, 2, 1'b0);
    chk("evt_5", {240'b0, bus.CD_out}, {240'b0, 16'd5});
    access(1'b1, 8'h24, 16'h0000, 2, 1'b0);
    chk("evt_cleared", {240'b0, bus.CD_out}, 256'h0);

    // event coinciding with the clearing read
    repeat (7) begin
      @(negedge clk); evt = 1'b1;
      @(negedge clk); evt = 1'b0;
    end
    access(1'b1, 8'h24, 16'h0000, 2, 1'b1);
    chk("evt_7", {240'b0, bus.CD_out}, {240'b0, 16'd7});
    access(1'b1, 8'h24, 16'h0000, 2, 1'b0);
    chk("evt_kept", {240'b0, bus.CD_out}, {240'b0, 16'd1});

    // saturation
    @(negedge clk); evt = 1'b1;
    repeat (70000) @(negedge clk);
    evt = 1'b0;
    access(1'b1, 8'h24, 16'h0000, 2, 1'b0);
    chk("evt_sat", {240'b0, bus.CD_out}, {240'b0, 16'hFFFF});

    // long CSB low period gives a single write
    p0 = pulse_cnt;
    access(1'b0, 8'h0A, 16'h5A5A, 10, 1'b0);
    exp_cfg[95:80] = 16'h5A5A;
    chk("long_pulse_count", 256'(pulse_cnt - p0), 256'd1);
    chk("long_addr", {252'b0, last_addr}, {252'b0, 4'd5});
    chk("long_cfg", cfg, exp_cfg);

    // reset before the write commits
    p0 = pulse_cnt;
    @(negedge clk);
    bus.CSB = 1'b0; bus.WRB = 1'b0; bus.CA = 8'h0E; bus.CD_in = 16'hBEEF;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cfg_cleared", cfg, 256'h0);
    rst = 1'b0; bus.CSB = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_reg7", {240'b0, cfg[127:112]}, 256'h0);
    chk("midrst_cd", {240'b0, bus.CD_out}, 256'h0);
    chk("midrst_no_pulse", 256'(pulse_cnt - p0), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/host_reg_slave.md
# host_reg_slave

Responder end of the host CPU register bus. Samples the host strobes (CSB, WRB) and address/data (CA, CD_in) in the Clk_reg domain, decodes one access per CSB assertion, updates a 16-entry configuration bank and drives read data onto CD_out. Sits between the host interface pins and the MAC configuration and statistics logic. It also provides an ID register, a status mirror and a read-to-clear event counter.

## Interface
- ID_VALUE, 16'hE7A0, constant returned at word address 0x10
- Clk_reg  input  1  register clock; all logic on rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- CSB  input  1  chip select, active low; one access per low period
- WRB  input  1  1 = read, 0 = write; valid while CSB low
- CA  input  8  byte address; word address = CA[7:1], CA[0] ignored
- CD_in  input  16  write data; valid while CSB low
- CD_out  output  16  registered read data
- Status_in  input  16  live status word, readable at 0x11
- Event  input  1  one-cycle event pulse, counted at 0x12
- Cfg_out  output  256  config bank, reg n at bits [16n+15:16n]
- Wr_pulse  output  1  one-cycle strobe after a committed write
- Wr_addr  output  4  index of the register written; valid with Wr_pulse

## Operation
- Input stage: CSB, WRB, CA and CD_in are registered once into csb_q, wrb_q, ca_q and d_q. csb_qq is a second registered copy of csb_q.
- Access detect: acc = (csb_q==0 && csb_qq==1). This is exactly one cycle per CSB low period, however long CSB stays low. Whether the access is a read or write is taken from wrb_q in that cycle. The address and data are taken from ca_q and d_q in that cycle.
- Address map, word address = ca_q[7:1]:
  - 0x00–0x0F: read/write config registers. Reset value 0x0000.
  - 0x10: read-only, returns ID_VALUE.
  - 0x11: read-only, returns Status_in sampled in the acc cycle.
  - 0x12: read-only event counter, read-to-clear, saturates at 0xFFFF.
  - 0x13–0x7F: reserved; reads return 0x0000, writes are ignored.
- Write to 0x00–0x0F: the register takes d_q at the edge ending the acc cycle. Wr_pulse=1 and Wr_addr=index in the following cycle.
- Write to 0x10–0x7F: no state change and no Wr_pulse. This includes writes to 0x12, which do not clear the counter.
- Read: CD_out takes the decoded value at the edge ending the acc cycle. CD_out then holds until the next read. Writes do not change CD_out.
- Event counter:
  - Increments by 1 on each cycle with Event=1, saturating at 0xFFFF.
  - On an acc read of 0x12, CD_out gets the pre-edge count. The counter is then loaded with 1 if Event=1 in the same cycle, else 0. No event is lost.
- Cfg_out is a direct, combinational-free view of the bank flops.

## Timing
- Host constraints:
  - CSB must stay low for ≥2 Clk_reg periods and high for ≥2 periods between accesses.
  - CA, CD_in and WRB must be stable for the whole low period.
  - The host is quasi-synchronous; no metastability synchronizer is provided.
- Latency, counting from the first rising edge that samples CSB low (edge E1):
  - The acc cycle follows E1.
  - The bank write and the CD_out update happen at E2.
  - Wr_pulse is high between E2 and E3.
- Back-to-back accesses at the minimum spacing give one Wr_pulse per write. Pulses never merge.
- Reset values: CD_out=0, Cfg_out=0, Wr_pulse=0, Wr_addr=0, event counter=0.
  - csb_q and csb_qq reset to 1, so a CSB that is already low when Reset releases is detected as a new access.
- Reset asserted mid-access: everything clears immediately. An access whose acc cycle had not yet committed is lost.

## Test plan
- Reset → CD_out=0x0000, Wr_pulse=0, all of Cfg_out=0. Then read 0x10 (CA=0x20) → CD_out=0xE7A0 two edges after CSB is sampled low.
- Write addr 0x03 (CA=0x06) with 0xA5C3, then read it back:
  - Wr_pulse is exactly one cycle wide with Wr_addr=3.
  - Cfg_out[63:48]=0xA5C3.
  - Read-back gives CD_out=0xA5C3.
- Write 0x1234 to 0x11 and 0x7F → no Wr_pulse and Cfg_out unchanged. Read 0x11 with Status_in=0x0F0F → CD_out=0x0F0F. Read 0x7F → 0x0000.
- Event counter:
  - Pulse Event 5 times, then read 0x12 → CD_out=5. A second read → 0.
  - Read 0x12 with Event=1 in the acc cycle after 7 prior events → CD_out=7. The next read → 1.
- Event counter saturation: hold Event high for 70000 cycles, read 0x12 → CD_out=0xFFFF.
- Hold CSB low for 10 cycles during a write → exactly one Wr_pulse. Assert Reset during a write's low period before E2 → register stays 0x0000.
